// File: rtl/sp_cfg_pkg.sv
// -----------------------------------------------------------------------------
// sp_cfg_pkg
// Shared definitions for the SuperMario configuration controller:
//   - controller state encoding
//   - SPI frame geometry (width, R/W bit position)
//   - default values for the controller parameters
//   - build_frame(): packs R/W, address and data into one SPI frame
// -----------------------------------------------------------------------------
package sp_cfg_pkg;

    localparam int FRAME_W        = 16;
    localparam int RW_BIT         = 15;

    localparam int RST_CYCLES_DEF = 16;
    localparam int GAP_CYCLES_DEF = 2;
    localparam int READ_LAT_DEF   = 1;
    localparam int MAX_REGS_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHIP_RST = 3'd1,
        GAP      = 3'd2,
        WR_FRAME = 3'd3,
        RD_FRAME = 3'd4,
        DONE     = 3'd5
    } state_t;

    // Frame layout, MSB first on the wire: [15] 1=write, [14:8] addr, [7:0] data.
    // Read frames carry zeros in the data field.
    function automatic logic [FRAME_W-1:0] build_frame(input logic       wr,
                                                       input logic [6:0] addr,
                                                       input logic [7:0] data);
        logic [FRAME_W-1:0] f;
        f         = '0;
        f[RW_BIT] = wr;
        f[14:8]   = addr;
        f[7:0]    = wr ? data : 8'h00;
        return f;
    endfunction

endpackage

// File: rtl/sp_spi_frame.sv
// -----------------------------------------------------------------------------
// sp_spi_frame
// Shifts one SPI frame to the chip, MSB first, one bit per clk cycle.
// A write frame keeps cs low for FRAME_W cycles; a read frame keeps it low for
// FRAME_W + READ_LAT cycles and samples MISO during the final 8 of them.
//
// Ports:
//   clk, rst     clock, async active-high reset (raises cs immediately)
//   load_i       start a frame (honoured only while no frame is active)
//   rd_i         frame is a read (extends the frame by READ_LAT cycles)
//   frame_i      frame contents, sampled with load_i
//   miso_i       serial data from the chip
//   cs_o         registered chip select, active-low
//   mosi_o       registered serial data to the chip
//   last_o       high during the final cs-low cycle of the frame
//   rx_byte_o    read-back byte; complete while last_o is high
// -----------------------------------------------------------------------------
module sp_spi_frame
    import sp_cfg_pkg::*;
#(
    parameter int READ_LAT = READ_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               rd_i,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic               miso_i,
    output logic               cs_o,
    output logic               mosi_o,
    output logic               last_o,
    output logic [7:0]         rx_byte_o
);

    localparam int RD_LEN = FRAME_W + READ_LAT;
    localparam int CNT_W  = $clog2(RD_LEN + 1);

    logic [FRAME_W-1:0] shreg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   last_q;
    logic [6:0]         rx_q;
    logic               cs_q;
    logic               mosi_q;
    logic               capture;

    // Data bits arrive in the final 8 cycles of the frame.
    assign capture = !cs_q && (cnt_q >= (last_q - CNT_W'(7)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            shreg_q <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            rx_q    <= '0;
        end else if (cs_q) begin
            if (load_i) begin
                // Bit 15 goes out with cs; the rest waits in the shifter.
                cs_q    <= 1'b0;
                mosi_q  <= frame_i[FRAME_W-1];
                shreg_q <= {frame_i[FRAME_W-2:0], 1'b0};
                cnt_q   <= '0;
                last_q  <= rd_i ? CNT_W'(RD_LEN - 1) : CNT_W'(FRAME_W - 1);
                rx_q    <= '0;
            end
        end else begin
            if (capture) begin
                rx_q <= {rx_q[5:0], miso_i};
            end
            if (cnt_q == last_q) begin
                cs_q   <= 1'b1;
                mosi_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_q + CNT_W'(1);
                mosi_q  <= shreg_q[FRAME_W-1];
                shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
            end
        end
    end

    assign cs_o      = cs_q;
    assign mosi_o    = mosi_q;
    assign last_o    = !cs_q && (cnt_q == last_q);
    // The last data bit is on miso during the final cycle; merge it in directly
    // so the controller can decide at the same edge that ends the frame.
    assign rx_byte_o = {rx_q, miso_i};

endmodule

// File: rtl/sp_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// sp_cfg_ctrl
// Configures a SuperMario chip: pulses its reset, writes a table of
// (addr, data) register entries over SPI, then optionally reads every entry
// back and counts mismatches.
//
// Ports:
//   clk, rst            clock (also the chip clock), async active-high reset
//   start               one-cycle pulse; begins a run from IDLE or DONE
//   verify_en, tbl_len  run options, sampled with start (len saturates)
//   tbl_idx             table index being fetched
//   tbl_addr, tbl_data  table entry at tbl_idx, valid in the same cycle
//   sp_nrst             chip reset, active-low
//   spi_cs/mosi/miso    SPI to the chip (cs active-low)
//   busy, done          run in progress / run complete (held until next start)
//   err, err_cnt, err_idx  verify result: sticky flag, count, first bad index
//
// Handshake: there is none on start. A start pulse seen in IDLE or DONE
// launches a run; while busy it is dropped without side effects.
// -----------------------------------------------------------------------------
module sp_cfg_ctrl
    import sp_cfg_pkg::*;
#(
    parameter int RST_CYCLES = RST_CYCLES_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int READ_LAT   = READ_LAT_DEF,
    parameter int MAX_REGS   = MAX_REGS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       verify_en,
    input  logic [4:0] tbl_len,
    output logic [3:0] tbl_idx,
    input  logic [6:0] tbl_addr,
    input  logic [7:0] tbl_data,
    output logic       sp_nrst,
    output logic       spi_cs,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [4:0] err_cnt,
    output logic [3:0] err_idx
);

    state_t             state_q;
    logic [15:0]        cnt_q;
    logic [4:0]         len_q;
    logic               verify_q;
    logic               rd_phase_q;
    logic [3:0]         idx_q;
    logic               nrst_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [4:0]         err_cnt_q;
    logic [3:0]         err_idx_q;

    logic [4:0]         len_sat;
    logic               load;
    logic               frame_last;
    logic               idx_is_last;
    logic [7:0]         rx_byte;
    logic [FRAME_W-1:0] frame;

    assign len_sat     = (tbl_len > 5'(MAX_REGS)) ? 5'(MAX_REGS) : tbl_len;
    // The table entry is captured on the edge that leaves the last GAP cycle.
    assign load        = (state_q == GAP) && (cnt_q == 16'(GAP_CYCLES - 1));
    assign frame       = build_frame(!rd_phase_q, tbl_addr, tbl_data);
    // Only consulted inside frames, where len_q is at least 1.
    assign idx_is_last = ({1'b0, idx_q} == (len_q - 5'd1));

    sp_spi_frame #(
        .READ_LAT (READ_LAT)
    ) u_frame (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .rd_i      (rd_phase_q),
        .frame_i   (frame),
        .miso_i    (spi_miso),
        .cs_o      (spi_cs),
        .mosi_o    (spi_mosi),
        .last_o    (frame_last),
        .rx_byte_o (rx_byte)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            verify_q   <= 1'b0;
            rd_phase_q <= 1'b0;
            idx_q      <= '0;
            nrst_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            err_idx_q  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= CHIP_RST;
                        cnt_q      <= '0;
                        len_q      <= len_sat;
                        verify_q   <= verify_en;
                        rd_phase_q <= 1'b0;
                        idx_q      <= '0;
                        nrst_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        err_cnt_q  <= '0;
                        err_idx_q  <= '0;
                    end
                end

                CHIP_RST: begin
                    if (cnt_q == 16'(RST_CYCLES - 1)) begin
                        cnt_q  <= '0;
                        nrst_q <= 1'b1;
                        if (len_q == 5'd0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= GAP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                GAP: begin
                    if (load) begin
                        cnt_q   <= '0;
                        state_q <= rd_phase_q ? RD_FRAME : WR_FRAME;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                WR_FRAME: begin
                    if (frame_last) begin
                        if (!idx_is_last) begin
                            idx_q   <= idx_q + 4'd1;
                            state_q <= GAP;
                        end else if (verify_q) begin
                            rd_phase_q <= 1'b1;
                            idx_q      <= '0;
                            state_q    <= GAP;
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end

                RD_FRAME: begin
                    if (frame_last) begin
                        // tbl_idx is unchanged during the frame, so tbl_data
                        // still holds the value that was written.
                        if (rx_byte != tbl_data) begin
                            err_q     <= 1'b1;
                            err_cnt_q <= err_cnt_q + 5'd1;
                            if (!err_q) begin
                                err_idx_q <= idx_q;
                            end
                        end
                        if (idx_is_last) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            state_q <= GAP;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    nrst_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tbl_idx = idx_q;
    assign sp_nrst = nrst_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign err_idx = err_idx_q;

endmodule

// File: doc/sp_cfg_ctrl.md
SP_CFG_CTRL -- requirements
Module: sp_cfg_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk, rst.
REQ-002 Parameters SHALL be, one per line:
  RST_CYCLES, 16, cycles sp_nrst is held low before configuration
  GAP_CYCLES, 2, cycles spi_cs stays high between frames
  READ_LAT, 1, cycles from the chip sampling the last address bit to spi_miso carrying data bit 7
  MAX_REGS, 16, table depth
REQ-003 Ports SHALL be, one per line:
  clk  in  1  system clock, also the SuperMario clock
  rst  in  1  async active-high reset
  start  in  1  single-cycle pulse that begins a configuration run
  verify_en  in  1  read-back verify after writes; sampled at start
  tbl_len  in  5  number of table entries to send; sampled at start
  tbl_idx  out  4  table index being fetched
  tbl_addr  in  7  register address at tbl_idx, valid in the same cycle
  tbl_data  in  8  register data at tbl_idx, valid in the same cycle
  sp_nrst  out  1  chip reset, active-low
  spi_cs  out  1  chip select, active-low
  spi_mosi  out  1  serial data to chip
  spi_miso  in  1  serial data from chip
  busy  out  1  run in progress
  done  out  1  run complete; held until next start
  err  out  1  sticky verify mismatch
  err_cnt  out  5  number of mismatching entries
  err_idx  out  4  index of the first mismatch

Function
REQ-004 Frame SHALL be 16 bits MSB-first: bit15 R/W (1=write), bits14:8 addr, bits7:0 data (0 on reads).
REQ-005 All SPI outputs SHALL be registered; spi_mosi SHALL change only on clk rising edges, one bit per cycle, with spi_cs low for the entire frame.
REQ-006 On read frames spi_cs SHALL stay low for 16+READ_LAT cycles; spi_miso SHALL be sampled in the final 8 cycles, MSB first.
REQ-007 FSM states SHALL be IDLE, CHIP_RST, GAP, WR_FRAME, RD_FRAME, DONE.
REQ-008 IDLE/DONE on start: latch tbl_len (saturate at MAX_REGS) and verify_en, clear err/err_cnt/err_idx/done, go to CHIP_RST.
REQ-009 CHIP_RST SHALL drive sp_nrst low for exactly RST_CYCLES cycles and then go to GAP with sp_nrst high.
REQ-010 GAP SHALL last GAP_CYCLES cycles and then start the next frame: writes for idx 0..len-1, then reads for idx 0..len-1 if verify_en, then DONE.
REQ-011 tbl_addr/tbl_data SHALL be captured into the shift register in the last GAP cycle.
REQ-012 Read-back byte not equal to tbl_data[idx]: increment err_cnt, set err; err_idx SHALL record the first mismatch only.
REQ-013 tbl_len=0 SHALL go CHIP_RST -> DONE with no frames.
REQ-014 start while busy SHALL be ignored; start in DONE SHALL begin a new run.
REQ-015 busy SHALL be high in every state except IDLE and DONE; done SHALL be high only in DONE.
REQ-016 sp_nrst SHALL be high in GAP, WR_FRAME, RD_FRAME and DONE, and low in IDLE and CHIP_RST.

Reset
REQ-017 Reset SHALL set: state IDLE, sp_nrst 0, spi_cs 1, spi_mosi 0, busy 0, done 0, err 0, err_cnt 0, err_idx 0, tbl_idx 0.
REQ-018 Reset mid-frame SHALL raise spi_cs and lower sp_nrst asynchronously; the aborted frame SHALL NOT resume.

Structure
REQ-019 Package sp_cfg_pkg SHALL hold the state enum, FRAME_W=16, the RW bit position and the parameter defaults.
REQ-020 One sub-module, sp_spi_frame, SHALL shift a single frame (load, shift, MISO capture, frame_done).

Verification
REQ-021 Reset, then start with tbl_len=3, verify_en=0, table {(0x01,0xA5),(0x02,0x3C),(0x7F,0xFF)} -> sp_nrst low 16 cycles; three frames 0x81A5, 0x823C, 0xFFFF, each with 16 cs-low cycles and 2-cycle gaps; done=1.
REQ-022 Same table with verify_en=1 and a chip model that echoes the register data -> three read frames 0x0100, 0x0200, 0x7F00 with 17 cs-low cycles; err=0, err_cnt=0.
REQ-023 Chip model returns 0x00 for idx1 and idx2 -> err=1, err_cnt=2, err_idx=1.
REQ-024 tbl_len=0 -> only the chip-reset pulse occurs, spi_cs never low, done=1; tbl_len=20 -> exactly 16 write frames.
REQ-025 start pulse during the second frame -> ignored, sequence unchanged; rst asserted at bit 7 of frame 2 -> spi_cs=1, sp_nrst=0 immediately, IDLE, busy=0.
